cfeb_hdl_top: RTL and testbench
===============================

// Module: cfeb_hdl_top
// PURPOSE
//  Trigger front end of the CFEB: decodes the 3-bit ENC_TRG bus into LCT/L1A/L1A_MATCH/RESYNC pulses,
//  holds slow-control config registers written by function code, and matches each L1A_MATCH against an
//  LCT seen a programmable latency earlier. It feeds SCA block bookkeeping and readout.
//  JTAG user-register access arrives already synchronised to CMSCLK as a cfg write strobe.
// PARAMETERS
//  SR_DEPTH   512  LCT history depth in cycles; must exceed 499+3+2.
//  CNT_W      12   width of accepted-L1A counter.
// PORTS
//  CMSCLK       in   1   40 MHz clock; the only clock.
//  RST          in   1   reset, asynchronous, active-high.
//  ENC_TRG      in   3   trigger bus, sampled on CMSCLK rising edge.
//  CFG_WE       in   1   one-cycle config write strobe.
//  CFG_FUNC     in   8   function code, valid with CFG_WE.
//  CFG_DATA     in   8   config data, LSB-aligned, valid with CFG_WE.
//  LCT,L1A,L1A_MATCH,RESYNC  out 1  decoded pulses, registered.
//  ACCEPT       out  1   L1A_MATCH matched a delayed LCT.
//  NO_LCT       out  1   L1A_MATCH with no LCT in window.
//  LCT_TIMEOUT  out  1   delayed LCT left window unmatched.
//  L1A_CNT      out  CNT_W  count of ACCEPT pulses.
//  XL1A[1:0], TRG_DCD, MTCH_3BX, LAT_12_5US, PRE_BLOCK_END[3:0], CMODE[1:0], CTIME[2:0]  out  config regs.
// BEHAVIOUR
//  Reset: all outputs and history 0. Config reset values: XL1A=0, TRG_DCD=0, MTCH_3BX=0, LAT_12_5US=0,
//   PRE_BLOCK_END=4'd3, CMODE=0, CTIME=0.
//  Decode: ENC_TRG sampled in cycle n drives its pulses in cycle n+1, one cycle per sampled cycle.
//   TRG_DCD=1: 0 none; 1 LCT; 2 LCT+L1A; 3 LCT+L1A+MATCH; 4 L1A; 5 L1A+MATCH; 6 none (reserved);
//    7 RESYNC only.
//   TRG_DCD=0: bit0=LCT, bit1=L1A, bit2=RESYNC, L1A_MATCH=L1A. RESYNC suppresses LCT/L1A/MATCH in the same cycle.
//  Config write, on CFG_WE, takes effect next cycle:
//   func 0 = no-op.
//   func 1 = internal RESYNC pulse.
//   func 5 = XL1A<=D[1:0].
//   func 6 = {TRG_DCD,MTCH_3BX,LAT_12_5US}<=D[2:0]; D[3] is ignored.
//   func 8 = PRE_BLOCK_END<=D[3:0].
//   func 9 = {CTIME,CMODE}<=D[4:0].
//   All other codes are ignored.
//  Latency: D = (LAT_12_5US ? 499 : 132) + XL1A. Range 132..502.
//  History: shift register of decoded LCT, shifting each cycle. Bit k set means an LCT occurred k+1 cycles ago.
//  Match: L1A_MATCH in cycle t is matched if an LCT pulse occurred at cycle t-D.
//   With MTCH_3BX=1 the window is t-D-1..t-D+1; the oldest candidate in the window wins.
//   On a match, ACCEPT pulses in cycle t+1, the matched history bit is cleared, and L1A_CNT increments with wrap.
//   On no match, NO_LCT pulses in cycle t+1.
//  L1A without MATCH only drives the L1A output; no ACCEPT or NO_LCT.
//  Timeout: an uncleared LCT reaching age D+1 (D+2 if MTCH_3BX) pulses LCT_TIMEOUT once, then is discarded.
//  Simultaneous match and aging in the same cycle: the match wins; no timeout.
//  RESYNC (decoded or func 1): synchronously clears history, L1A_CNT, ACCEPT/NO_LCT/LCT_TIMEOUT next cycle.
//   A held RESYNC keeps everything cleared. Config registers are unaffected.
//  Changing D while LCTs are in flight is legal: matching uses the current D; no error is flagged.
// STRUCTURE
//  Package cfeb_pkg: function-code constants (FN_NOOP=0, FN_SCAM_RST=1, FN_XL1A=5, FN_CFG=6, FN_PBE=8,
//   FN_CMP=9), trigger-code constants, LAT_BASE_SHORT=132, LAT_BASE_LONG=499.
//  One submodule, cfeb_trg_dcd: combinational ENC_TRG/TRG_DCD decode; registering is done in the top.
// TESTING
//  1. Reset, then read config outputs -> XL1A=0, PRE_BLOCK_END=3, TRG_DCD=0; all pulses 0, L1A_CNT=0.
//  2. Writes func5 D=1, func8 D=3, func6 D=4'b0100 -> XL1A=1, PRE_BLOCK_END=3, TRG_DCD=1, D=133.
//  3. TRG_DCD=1: ENC_TRG=1 at cycle c, ENC_TRG=3 at c+133 -> ACCEPT at c+135, L1A_CNT=1, no timeout.
//  4. Same as 3 but L1A at c+134: MTCH_3BX=0 -> NO_LCT and LCT_TIMEOUT; MTCH_3BX=1 -> ACCEPT.
//  5. Codes 1,4,5,2,3 spaced 6 cycles apart -> matching decoded pulses.
//     Code 7 held 25 cycles -> RESYNC each cycle, L1A_CNT=0.
//  6. LAT_12_5US=1, XL1A=1: LCT, then MATCH 500 cycles later -> ACCEPT.
//     Then func1 mid-flight after a new LCT -> no later ACCEPT or timeout.

Source files
------------

// File: rtl/cfeb_pkg.sv
// Shared constants for the CFEB trigger front end: slow-control function codes,
// ENC_TRG trigger codes and the L1A latency base values.
package cfeb_pkg;

  localparam logic [7:0] FN_NOOP     = 8'd0;
  localparam logic [7:0] FN_SCAM_RST = 8'd1;
  localparam logic [7:0] FN_XL1A     = 8'd5;
  localparam logic [7:0] FN_CFG      = 8'd6;
  localparam logic [7:0] FN_PBE      = 8'd8;
  localparam logic [7:0] FN_CMP      = 8'd9;

  localparam logic [2:0] TRG_NONE         = 3'd0;
  localparam logic [2:0] TRG_LCT          = 3'd1;
  localparam logic [2:0] TRG_LCT_L1A      = 3'd2;
  localparam logic [2:0] TRG_LCT_L1A_MTCH = 3'd3;
  localparam logic [2:0] TRG_L1A          = 3'd4;
  localparam logic [2:0] TRG_L1A_MTCH     = 3'd5;
  localparam logic [2:0] TRG_RSVD         = 3'd6;
  localparam logic [2:0] TRG_RESYNC       = 3'd7;

  localparam int unsigned LAT_BASE_SHORT = 132;
  localparam int unsigned LAT_BASE_LONG  = 499;

  // L1A latency in CMSCLK cycles, 132..502.
  function automatic logic [9:0] calc_lat(input logic lat_long, input logic [1:0] xl1a);
    logic [9:0] base;
    base = lat_long ? 10'(LAT_BASE_LONG) : 10'(LAT_BASE_SHORT);
    return base + {8'd0, xl1a};
  endfunction

endpackage

// File: rtl/cfeb_trg_dcd.sv
// Combinational ENC_TRG decoder; selects the table-driven (TRG_DCD=1) or
// bit-mapped (TRG_DCD=0) interpretation of the trigger bus.
module cfeb_trg_dcd
  import cfeb_pkg::*;
(
  input  logic [2:0] enc_trg_i,
  input  logic       trg_dcd_i,
  output logic       lct_o,
  output logic       l1a_o,
  output logic       l1a_match_o,
  output logic       resync_o
);

  always_comb begin
    lct_o       = 1'b0;
    l1a_o       = 1'b0;
    l1a_match_o = 1'b0;
    resync_o    = 1'b0;
    if (trg_dcd_i) begin
      case (enc_trg_i)
        TRG_NONE:         ;
        TRG_LCT:          lct_o = 1'b1;
        TRG_LCT_L1A: begin
          lct_o = 1'b1;
          l1a_o = 1'b1;
        end
        TRG_LCT_L1A_MTCH: begin
          lct_o       = 1'b1;
          l1a_o       = 1'b1;
          l1a_match_o = 1'b1;
        end
        TRG_L1A:          l1a_o = 1'b1;
        TRG_L1A_MTCH: begin
          l1a_o       = 1'b1;
          l1a_match_o = 1'b1;
        end
        TRG_RSVD:         ;
        TRG_RESYNC:       resync_o = 1'b1;
        default:          ;
      endcase
    end else begin
      // RESYNC on bit 2 masks any LCT/L1A encoded alongside it.
      resync_o    = enc_trg_i[2];
      lct_o       = enc_trg_i[0] & ~enc_trg_i[2];
      l1a_o       = enc_trg_i[1] & ~enc_trg_i[2];
      l1a_match_o = enc_trg_i[1] & ~enc_trg_i[2];
    end
  end

endmodule

// File: rtl/cfeb_hdl_top.sv
// CFEB trigger front end: registered trigger decode, slow-control config registers,
// and L1A_MATCH-to-LCT latency matching over a shift-register LCT history.
module cfeb_hdl_top
  import cfeb_pkg::*;
#(
  parameter int unsigned SR_DEPTH = 512,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             CMSCLK,
  input  logic             RST,
  input  logic [2:0]       ENC_TRG,
  input  logic             CFG_WE,
  input  logic [7:0]       CFG_FUNC,
  input  logic [7:0]       CFG_DATA,
  output logic             LCT,
  output logic             L1A,
  output logic             L1A_MATCH,
  output logic             RESYNC,
  output logic             ACCEPT,
  output logic             NO_LCT,
  output logic             LCT_TIMEOUT,
  output logic [CNT_W-1:0] L1A_CNT,
  output logic [1:0]       XL1A,
  output logic             TRG_DCD,
  output logic             MTCH_3BX,
  output logic             LAT_12_5US,
  output logic [3:0]       PRE_BLOCK_END,
  output logic [1:0]       CMODE,
  output logic [2:0]       CTIME
);

  logic dec_lct, dec_l1a, dec_mtch, dec_rs;
  logic lct_q, l1a_q, l1a_match_q, resync_q;
  logic scam_rst_q, scam_rst_d;

  logic [1:0] xl1a_q, xl1a_d;
  logic       trg_dcd_q, trg_dcd_d;
  logic       mtch_3bx_q, mtch_3bx_d;
  logic       lat_long_q, lat_long_d;
  logic [3:0] pbe_q, pbe_d;
  logic [1:0] cmode_q, cmode_d;
  logic [2:0] ctime_q, ctime_d;

  logic [SR_DEPTH-1:0] hist_q, hist_d, hist_m;
  logic                accept_q, accept_d;
  logic                no_lct_q, no_lct_d;
  logic                tmo_q, tmo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [9:0]  lat_cyc;
  int unsigned lat_u, win_lo, win_hi, tmo_idx, match_sel;
  logic        match_hit, tmo_hit;

  logic unused_cfg_data;
  assign unused_cfg_data = ^CFG_DATA[7:5];

  cfeb_trg_dcd u_trg_dcd (
    .enc_trg_i   (ENC_TRG),
    .trg_dcd_i   (trg_dcd_q),
    .lct_o       (dec_lct),
    .l1a_o       (dec_l1a),
    .l1a_match_o (dec_mtch),
    .resync_o    (dec_rs)
  );

  always_comb begin
    xl1a_d     = xl1a_q;
    trg_dcd_d  = trg_dcd_q;
    mtch_3bx_d = mtch_3bx_q;
    lat_long_d = lat_long_q;
    pbe_d      = pbe_q;
    cmode_d    = cmode_q;
    ctime_d    = ctime_q;
    scam_rst_d = 1'b0;
    if (CFG_WE) begin
      case (CFG_FUNC)
        FN_NOOP:     ;
        FN_SCAM_RST: scam_rst_d = 1'b1;
        FN_XL1A:     xl1a_d = CFG_DATA[1:0];
        FN_CFG:      {trg_dcd_d, mtch_3bx_d, lat_long_d} = CFG_DATA[2:0];
        FN_PBE:      pbe_d = CFG_DATA[3:0];
        FN_CMP:      {ctime_d, cmode_d} = CFG_DATA[4:0];
        default:     ;
      endcase
    end
  end

  // History bit k holds an LCT that is k+1 cycles old, so latency D lives at index D-1.
  assign lat_cyc = calc_lat(lat_long_q, xl1a_q);

  always_comb begin
    lat_u   = {22'd0, lat_cyc};
    win_hi  = mtch_3bx_q ? lat_u : lat_u - 1;
    win_lo  = mtch_3bx_q ? lat_u - 2 : lat_u - 1;
    tmo_idx = mtch_3bx_q ? lat_u + 1 : lat_u;
  end

  always_comb begin
    match_hit = 1'b0;
    match_sel = 0;
    // Scanning upward leaves the oldest hit in the window selected.
    for (int unsigned k = 0; k < SR_DEPTH; k++) begin
      if (l1a_match_q && hist_q[k] && (k >= win_lo) && (k <= win_hi)) begin
        match_hit = 1'b1;
        match_sel = k;
      end
    end
    hist_m  = hist_q;
    tmo_hit = 1'b0;
    // Clearing the matched bit first lets a match beat a same-cycle timeout.
    for (int unsigned k = 0; k < SR_DEPTH; k++) begin
      if (match_hit && (k == match_sel)) hist_m[k] = 1'b0;
      if (k == tmo_idx) tmo_hit = hist_m[k];
      if (k >= tmo_idx) hist_m[k] = 1'b0;
    end
  end

  always_comb begin
    hist_d   = {hist_m[SR_DEPTH-2:0], lct_q};
    accept_d = match_hit;
    no_lct_d = l1a_match_q & ~match_hit;
    tmo_d    = tmo_hit;
    cnt_d    = cnt_q + CNT_W'(match_hit);
    if (resync_q || scam_rst_q) begin
      hist_d   = '0;
      accept_d = 1'b0;
      no_lct_d = 1'b0;
      tmo_d    = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge CMSCLK or posedge RST) begin
    if (RST) begin
      lct_q       <= 1'b0;
      l1a_q       <= 1'b0;
      l1a_match_q <= 1'b0;
      resync_q    <= 1'b0;
      scam_rst_q  <= 1'b0;
      xl1a_q      <= 2'd0;
      trg_dcd_q   <= 1'b0;
      mtch_3bx_q  <= 1'b0;
      lat_long_q  <= 1'b0;
      pbe_q       <= 4'd3;
      cmode_q     <= 2'd0;
      ctime_q     <= 3'd0;
      hist_q      <= '0;
      accept_q    <= 1'b0;
      no_lct_q    <= 1'b0;
      tmo_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      lct_q       <= dec_lct;
      l1a_q       <= dec_l1a;
      l1a_match_q <= dec_mtch;
      resync_q    <= dec_rs;
      scam_rst_q  <= scam_rst_d;
      xl1a_q      <= xl1a_d;
      trg_dcd_q   <= trg_dcd_d;
      mtch_3bx_q  <= mtch_3bx_d;
      lat_long_q  <= lat_long_d;
      pbe_q       <= pbe_d;
      cmode_q     <= cmode_d;
      ctime_q     <= ctime_d;
      hist_q      <= hist_d;
      accept_q    <= accept_d;
      no_lct_q    <= no_lct_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign LCT           = lct_q;
  assign L1A           = l1a_q;
  assign L1A_MATCH     = l1a_match_q;
  assign RESYNC        = resync_q;
  assign ACCEPT        = accept_q;
  assign NO_LCT        = no_lct_q;
  assign LCT_TIMEOUT   = tmo_q;
  assign L1A_CNT       = cnt_q;
  assign XL1A          = xl1a_q;
  assign TRG_DCD       = trg_dcd_q;
  assign MTCH_3BX      = mtch_3bx_q;
  assign LAT_12_5US    = lat_long_q;
  assign PRE_BLOCK_END = pbe_q;
  assign CMODE         = cmode_q;
  assign CTIME         = ctime_q;

endmodule

// File: tb/tb_cfeb_hdl_top.sv
// Scoreboard bench for cfeb_hdl_top: a time-stamped LCT list model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_cfeb_hdl_top;

  logic        CMSCLK, RST, CFG_WE;
  logic [2:0]  ENC_TRG;
  logic [7:0]  CFG_FUNC, CFG_DATA;
  logic        LCT, L1A, L1A_MATCH, RESYNC, ACCEPT, NO_LCT, LCT_TIMEOUT;
  logic [11:0] L1A_CNT;
  logic [1:0]  XL1A, CMODE;
  logic        TRG_DCD, MTCH_3BX, LAT_12_5US;
  logic [3:0]  PRE_BLOCK_END;
  logic [2:0]  CTIME;

  typedef struct packed {
    logic        lct, l1a, mt, rs, acc, nol, tmo;
    logic [11:0] cnt;
    logic [1:0]  xl1a;
    logic        dcd, m3, lat;
    logic [3:0]  pbe;
    logic [1:0]  cmode;
    logic [2:0]  ctime;
  } obs_t;

  obs_t cur, rst_vec, exp_q[$];
  logic m_scam;
  int   pend[$];
  int   ncyc;
  int   total, bad;

  logic [2:0] r_e;
  logic       r_we;
  logic [7:0] r_f, r_d;
  int         r_pick, r_tgt;
  logic [7:0] fn_list [0:8];

  cfeb_hdl_top dut (
    .CMSCLK(CMSCLK), .RST(RST), .ENC_TRG(ENC_TRG), .CFG_WE(CFG_WE), .CFG_FUNC(CFG_FUNC),
    .CFG_DATA(CFG_DATA), .LCT(LCT), .L1A(L1A), .L1A_MATCH(L1A_MATCH), .RESYNC(RESYNC),
    .ACCEPT(ACCEPT), .NO_LCT(NO_LCT), .LCT_TIMEOUT(LCT_TIMEOUT), .L1A_CNT(L1A_CNT),
    .XL1A(XL1A), .TRG_DCD(TRG_DCD), .MTCH_3BX(MTCH_3BX), .LAT_12_5US(LAT_12_5US),
    .PRE_BLOCK_END(PRE_BLOCK_END), .CMODE(CMODE), .CTIME(CTIME)
  );

  initial begin
    CMSCLK = 1'b0;
    forever #5 CMSCLK = ~CMSCLK;
  end

  function automatic obs_t sample();
    obs_t a;
    a = {LCT, L1A, L1A_MATCH, RESYNC, ACCEPT, NO_LCT, LCT_TIMEOUT, L1A_CNT, XL1A, TRG_DCD,
         MTCH_3BX, LAT_12_5US, PRE_BLOCK_END, CMODE, CTIME};
    return a;
  endfunction

  function automatic void dec(input logic dcd, input logic [2:0] e,
                              output logic l, output logic a, output logic m, output logic r);
    l = 0; a = 0; m = 0; r = 0;
    if (dcd) begin
      case (e)
        3'd1: l = 1;
        3'd2: begin l = 1; a = 1; end
        3'd3: begin l = 1; a = 1; m = 1; end
        3'd4: a = 1;
        3'd5: begin a = 1; m = 1; end
        3'd7: r = 1;
        default: ;
      endcase
    end else begin
      r = e[2];
      l = e[0] & ~e[2];
      a = e[1] & ~e[2];
      m = a;
    end
  endfunction

  function automatic int lat_of(input obs_t o);
    return (o.lat ? 499 : 132) + int'(o.xl1a);
  endfunction

  function automatic int pend_idx(input int s);
    for (int j = 0; j < pend.size(); j++) if (pend[j] == s) return j;
    return -1;
  endfunction

  // One clock edge of the reference model; cur describes cycle ncyc.
  task automatic model_step(input logic [2:0] e, input logic we, input logic [7:0] f,
                            input logic [7:0] d);
    obs_t p, x;
    int   t, dd, a, idx;
    logic sc;
    p = cur;
    x = p;
    t = ncyc;
    dec(p.dcd, e, x.lct, x.l1a, x.mt, x.rs);
    sc = we && (f == 8'd1);
    if (we) begin
      case (f)
        8'd5: x.xl1a = d[1:0];
        8'd6: begin x.dcd = d[2]; x.m3 = d[1]; x.lat = d[0]; end
        8'd8: x.pbe = d[3:0];
        8'd9: begin x.ctime = d[4:2]; x.cmode = d[1:0]; end
        default: ;
      endcase
    end
    x.acc = 0; x.nol = 0; x.tmo = 0;
    if (p.rs || m_scam) begin
      pend.delete();
      x.cnt = 0;
    end else begin
      dd = lat_of(p);
      a  = dd + (p.m3 ? 2 : 1);
      if (p.mt) begin
        idx = -1;
        if (p.m3) idx = pend_idx(t - dd - 1);
        if (idx < 0) idx = pend_idx(t - dd);
        if (idx < 0 && p.m3) idx = pend_idx(t - dd + 1);
        if (idx >= 0) begin
          pend.delete(idx);
          x.acc = 1;
          x.cnt = p.cnt + 12'd1;
        end else begin
          x.nol = 1;
        end
      end
      for (int j = pend.size() - 1; j >= 0; j--) begin
        if (t - pend[j] == a) begin
          x.tmo = 1;
          pend.delete(j);
        end else if (t - pend[j] > a) begin
          pend.delete(j);
        end
      end
      if (p.lct) pend.push_back(t);
    end
    m_scam = sc;
    cur = x;
    ncyc++;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input logic [2:0] e, input logic we, input logic [7:0] f,
                     input logic [7:0] d);
    ENC_TRG = e; CFG_WE = we; CFG_FUNC = f; CFG_DATA = d;
    @(posedge CMSCLK);
    model_step(e, we, f, d);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(3'd0, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(negedge CMSCLK);
      if (!RST && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL obs cyc=%0d got=%h want=%h", ncyc, a, e);
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; ncyc = 0; m_scam = 0;
    rst_vec = '0;
    rst_vec.pbe = 4'd3;
    cur = rst_vec;
    fn_list = '{8'd0, 8'd1, 8'd5, 8'd6, 8'd8, 8'd9, 8'd2, 8'd7, 8'd255};
    ENC_TRG = 0; CFG_WE = 0; CFG_FUNC = 0; CFG_DATA = 0;
    RST = 1'b1;
    repeat (3) @(posedge CMSCLK);
    @(negedge CMSCLK);
    total++;
    if (sample() !== rst_vec) begin
      bad++;
      $display("FAIL reset got=%h want=%h", sample(), rst_vec);
    end
    @(posedge CMSCLK);
    #1 RST = 1'b0;

    // Config: XL1A=1, PRE_BLOCK_END=3, TRG_DCD=1 -> latency 133.
    cyc(3'd0, 1'b1, 8'd5, 8'd1);
    cyc(3'd0, 1'b1, 8'd8, 8'd3);
    cyc(3'd0, 1'b1, 8'd6, 8'h04);
    idle(3);

    // Exact-latency match.
    cyc(3'd1, 0, 0, 0); idle(132); cyc(3'd3, 0, 0, 0); idle(140);
    // One cycle late, single-BX window then three-BX window.
    cyc(3'd1, 0, 0, 0); idle(133); cyc(3'd5, 0, 0, 0); idle(140);
    cyc(3'd0, 1'b1, 8'd6, 8'h06); idle(2);
    cyc(3'd1, 0, 0, 0); idle(133); cyc(3'd5, 0, 0, 0); idle(140);
    cyc(3'd0, 1'b1, 8'd6, 8'h0c); idle(2);

    // Decode sweep and held RESYNC.
    cyc(3'd1, 0, 0, 0); idle(5);
    cyc(3'd4, 0, 0, 0); idle(5);
    cyc(3'd5, 0, 0, 0); idle(5);
    cyc(3'd2, 0, 0, 0); idle(5);
    cyc(3'd3, 0, 0, 0); idle(5);
    repeat (25) cyc(3'd7, 0, 0, 0);
    idle(5);

    // Long latency (500), then func1 RESYNC with an LCT in flight.
    cyc(3'd0, 1'b1, 8'd6, 8'h05); idle(2);
    cyc(3'd1, 0, 0, 0); idle(499); cyc(3'd5, 0, 0, 0); idle(10);
    cyc(3'd1, 0, 0, 0); idle(100); cyc(3'd0, 1'b1, 8'd1, 8'd0); idle(398);
    cyc(3'd5, 0, 0, 0); idle(20);
    cyc(3'd0, 1'b1, 8'd6, 8'h04); idle(2);

    // Randomized traffic, biased toward L1A_MATCH near pending LCTs.
    for (int i = 0; i < 4000; i++) begin
      r_e = 3'd0; r_we = 1'b0; r_f = 8'd0; r_d = 8'($urandom);
      r_pick = $urandom_range(0, 99);
      r_tgt = ncyc + 1 - lat_of(cur);
      if ((pend_idx(r_tgt) >= 0 || pend_idx(r_tgt - 1) >= 0 || pend_idx(r_tgt + 1) >= 0)
          && $urandom_range(0, 2) != 0) begin
        r_e = 3'd5;
      end else if (r_pick < 8) begin
        r_e = 3'd1;
      end else if (r_pick < 13) begin
        r_e = 3'($urandom_range(1, 7));
        if (r_e == 3'd7 && $urandom_range(0, 3) != 0) r_e = 3'd1;
      end
      if ($urandom_range(0, 249) == 0) begin
        r_we = 1'b1;
        r_f = fn_list[$urandom_range(0, 8)];
        if (r_f == 8'd6 && $urandom_range(0, 3) != 0) r_d[2] = 1'b1;
      end
      cyc(r_e, r_we, r_f, r_d);
    end
    idle(5);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CMSCLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
